// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation station: CDB operand wakeup, oldest-ready issue
// Age is kept as a pairwise matrix: older_q[j][i] set means entry j was allocated before entry i.
module rs_issue_queue #(
    parameter  int DEPTH   = 4,
    parameter  int NUM_CDB = 2,
    parameter  int TAG_W   = 6,
    parameter  int DATA_W  = 32,
    parameter  int OP_W    = 10,
    parameter  int IMM_W   = 32,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      kill_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [OP_W-1:0]           in_op_i,
    input  logic [TAG_W-1:0]          in_dest_i,
    input  logic                      in_v1_i,
    input  logic [DATA_W-1:0]         in_opr1_i,
    input  logic                      in_v2_i,
    input  logic [DATA_W-1:0]         in_opr2_i,
    input  logic [IMM_W-1:0]          in_imm_i,
    input  logic [NUM_CDB-1:0]        cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [OP_W-1:0]           out_op_o,
    output logic [TAG_W-1:0]          out_dest_o,
    output logic [DATA_W-1:0]         out_opr1_o,
    output logic [DATA_W-1:0]         out_opr2_o,
    output logic [IMM_W-1:0]          out_imm_o,
    output logic [CNT_W-1:0]          count_o
);

    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [DEPTH-1:0]            v1_q, v1_d, v2_q, v2_d;
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [OP_W-1:0]             op_q   [DEPTH];
    logic [OP_W-1:0]             op_d   [DEPTH];
    logic [TAG_W-1:0]            dest_q [DEPTH];
    logic [TAG_W-1:0]            dest_d [DEPTH];
    logic [DATA_W-1:0]           opr1_q [DEPTH];
    logic [DATA_W-1:0]           opr1_d [DEPTH];
    logic [DATA_W-1:0]           opr2_q [DEPTH];
    logic [DATA_W-1:0]           opr2_d [DEPTH];
    logic [IMM_W-1:0]            imm_q  [DEPTH];
    logic [IMM_W-1:0]            imm_d  [DEPTH];

    logic [DEPTH-1:0] free, alloc_oh, ready, sel;
    logic             alloc_go, issue_go;
    logic [DATA_W:0]  byp1, byp2, wk;

    // Returns {hit, data}; scanning downward lets the lowest matching port win.
    function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid_i[k] && cdb_tag_i[k*TAG_W +: TAG_W] == tag)
                r = {1'b1, cdb_data_i[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    assign in_ready_o = (count_q < CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign free       = ~busy_q;
    assign alloc_oh   = free & (~free + 1'b1);
    assign ready      = busy_q & v1_q & v2_q;
    assign alloc_go   = in_valid_i && in_ready_o && !kill_i;
    assign issue_go   = out_valid_o && out_ready_i;

    always_comb begin
        sel        = ready;
        out_op_o   = '0;
        out_dest_o = '0;
        out_opr1_o = '0;
        out_opr2_o = '0;
        out_imm_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older_q[j][i])
                    sel[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                out_op_o   = op_q[i];
                out_dest_o = dest_q[i];
                out_opr1_o = opr1_q[i];
                out_opr2_o = opr2_q[i];
                out_imm_o  = imm_q[i];
            end
        end
        out_valid_o = (|ready) && !kill_i;
    end

    always_comb begin
        busy_d  = busy_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        older_d = older_q;
        op_d    = op_q;
        dest_d  = dest_q;
        opr1_d  = opr1_q;
        opr2_d  = opr2_q;
        imm_d   = imm_q;
        count_d = count_q + CNT_W'(alloc_go) - CNT_W'(issue_go);
        byp1    = cdb_match(in_opr1_i[TAG_W-1:0]);
        byp2    = cdb_match(in_opr2_i[TAG_W-1:0]);
        wk      = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && !v1_q[i]) begin
                wk = cdb_match(opr1_q[i][TAG_W-1:0]);
                if (wk[DATA_W]) begin
                    v1_d[i]   = 1'b1;
                    opr1_d[i] = wk[DATA_W-1:0];
                end
            end
            if (busy_q[i] && !v2_q[i]) begin
                wk = cdb_match(opr2_q[i][TAG_W-1:0]);
                if (wk[DATA_W]) begin
                    v2_d[i]   = 1'b1;
                    opr2_d[i] = wk[DATA_W-1:0];
                end
            end
            if (issue_go && sel[i])
                busy_d[i] = 1'b0;
            if (alloc_go && alloc_oh[i]) begin
                busy_d[i] = 1'b1;
                op_d[i]   = in_op_i;
                dest_d[i] = in_dest_i;
                imm_d[i]  = in_imm_i;
                v1_d[i]   = in_v1_i | byp1[DATA_W];
                opr1_d[i] = (!in_v1_i && byp1[DATA_W]) ? byp1[DATA_W-1:0] : in_opr1_i;
                v2_d[i]   = in_v2_i | byp2[DATA_W];
                opr2_d[i] = (!in_v2_i && byp2[DATA_W]) ? byp2[DATA_W-1:0] : in_opr2_i;
                // New entry is younger than every other slot; stale bits for free slots are rewritten when they allocate.
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[i][j] = 1'b0;
                    if (j != i)
                        older_d[j][i] = 1'b1;
                end
            end
        end

        if (kill_i) begin
            busy_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            older_q <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            older_q <= older_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        dest_q <= dest_d;
        opr1_q <= opr1_d;
        opr2_q <= opr2_d;
        imm_q  <= imm_d;
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed self-checking bench for rs_issue_queue
module tb_rs_issue_queue;

    logic        clk = 1'b0;
    logic        reset, kill_i, in_valid_i, in_ready_o;
    logic [9:0]  in_op_i;
    logic [5:0]  in_dest_i;
    logic        in_v1_i, in_v2_i;
    logic [31:0] in_opr1_i, in_opr2_i, in_imm_i;
    logic [1:0]  cdb_valid_i;
    logic [11:0] cdb_tag_i;
    logic [63:0] cdb_data_i;
    logic        out_valid_o, out_ready_i;
    logic [9:0]  out_op_o;
    logic [5:0]  out_dest_o;
    logic [31:0] out_opr1_o, out_opr2_o, out_imm_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    rs_issue_queue dut (
        .clk(clk), .reset(reset), .kill_i(kill_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_op_i(in_op_i), .in_dest_i(in_dest_i),
        .in_v1_i(in_v1_i), .in_opr1_i(in_opr1_i),
        .in_v2_i(in_v2_i), .in_opr2_i(in_opr2_i), .in_imm_i(in_imm_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_op_o(out_op_o), .out_dest_o(out_dest_o),
        .out_opr1_o(out_opr1_o), .out_opr2_o(out_opr2_o), .out_imm_o(out_imm_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        kill_i      = 1'b0;
        in_valid_i  = 1'b0;
        cdb_valid_i = 2'b00;
        #1;
    endtask

    task automatic alloc(input logic [9:0] op, input logic v1, input logic [31:0] o1,
                         input logic v2, input logic [31:0] o2);
        in_valid_i = 1'b1;
        in_op_i    = op;
        in_dest_i  = op[5:0];
        in_v1_i    = v1;
        in_opr1_i  = o1;
        in_v2_i    = v2;
        in_opr2_i  = o2;
        in_imm_i   = 32'h100 + 32'(op);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready_i = 1'b0;
        idle();
        cyc(); cyc();
        reset = 1'b0;
        #1;
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1;
        alloc(10'h005, 1'b1, 32'd10, 1'b1, 32'd20);
        in_dest_i = 6'd3; in_imm_i = 32'h40;
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid got %b want 0", out_valid_o); end
        cyc();
        idle();
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid_o); end
        n_checks++; if (out_op_o !== 10'h005) begin n_fail++; $display("FAIL basic_op got %h want 005", out_op_o); end
        n_checks++; if (out_dest_o !== 6'd3) begin n_fail++; $display("FAIL basic_dest got %0d want 3", out_dest_o); end
        n_checks++; if (out_opr1_o !== 32'd10) begin n_fail++; $display("FAIL basic_opr1 got %0d want 10", out_opr1_o); end
        n_checks++; if (out_opr2_o !== 32'd20) begin n_fail++; $display("FAIL basic_opr2 got %0d want 20", out_opr2_o); end
        n_checks++; if (out_imm_o !== 32'h40) begin n_fail++; $display("FAIL basic_imm got %h want 40", out_imm_o); end
        n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL basic_count1 got %0d want 1", count_o); end
        cyc();
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL basic_count0 got %0d want 0", count_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b want 0", out_valid_o); end
    endtask

    task automatic test_wakeup();
        out_ready_i = 1'b1;
        alloc(10'h001, 1'b0, 32'd7, 1'b1, 32'd2);
        cyc();
        alloc(10'h002, 1'b1, 32'd3, 1'b1, 32'd4);
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL wake_not_ready got %b want 0", out_valid_o); end
        cyc();
        idle();
        // Port 0 carries the same tag but is not valid, so only port 1 may wake A.
        cdb_valid_i = 2'b10; cdb_tag_i = {6'd7, 6'd7}; cdb_data_i = {32'hDEAD, 32'hBEEF};
        #1;
        n_checks++; if (out_valid_o !== 1'b1 || out_op_o !== 10'h002) begin n_fail++; $display("FAIL wake_b_first got v=%b op=%h want v=1 op=002", out_valid_o, out_op_o); end
        cyc();
        idle();
        n_checks++; if (out_valid_o !== 1'b1 || out_op_o !== 10'h001) begin n_fail++; $display("FAIL wake_a_next got v=%b op=%h want v=1 op=001", out_valid_o, out_op_o); end
        n_checks++; if (out_opr1_o !== 32'hDEAD) begin n_fail++; $display("FAIL wake_a_opr1 got %h want dead", out_opr1_o); end
        cyc();
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL wake_count got %0d want 0", count_o); end
    endtask

    task automatic test_full();
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc(10'h010 + 10'(i), 1'b0, 32'd9, 1'b1, 32'd1);
            cyc();
        end
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready_o); end
        alloc(10'h01F, 1'b1, 32'd0, 1'b1, 32'd0);
        cyc();
        idle();
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_ignored got %0d want 4", count_o); end
        cdb_valid_i = 2'b01; cdb_tag_i = {6'd0, 6'd9}; cdb_data_i = {32'h0, 32'h99};
        #1;
        cyc();
        idle();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid_o !== 1'b1 || out_op_o !== 10'h010 + 10'(i) || out_opr1_o !== 32'h99) begin
                n_fail++;
                $display("FAIL full_order_%0d got v=%b op=%h opr1=%h want v=1 op=%h opr1=99", i, out_valid_o, out_op_o, out_opr1_o, 10'h010 + 10'(i));
            end
            cyc();
        end
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d want 0", count_o); end
    endtask

    task automatic test_bypass();
        out_ready_i = 1'b1;
        alloc(10'h030, 1'b1, 32'd1, 1'b0, 32'd5);
        // Both ports hit tag 5; the lower-numbered port must supply the data.
        cdb_valid_i = 2'b11; cdb_tag_i = {6'd5, 6'd5}; cdb_data_i = {32'h9999, 32'h1234};
        #1;
        cyc();
        idle();
        n_checks++; if (out_valid_o !== 1'b1 || out_op_o !== 10'h030) begin n_fail++; $display("FAIL bypass_valid got v=%b op=%h want v=1 op=030", out_valid_o, out_op_o); end
        n_checks++; if (out_opr2_o !== 32'h1234) begin n_fail++; $display("FAIL bypass_opr2 got %h want 1234", out_opr2_o); end
        cyc();
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL bypass_count got %0d want 0", count_o); end
    endtask

    task automatic test_hold_age();
        out_ready_i = 1'b0;
        alloc(10'h021, 1'b0, 32'd12, 1'b1, 32'd0);
        cyc();
        alloc(10'h022, 1'b1, 32'd1, 1'b1, 32'd2);
        cyc();
        alloc(10'h023, 1'b1, 32'd1, 1'b1, 32'd2);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid_o !== 1'b1 || out_op_o !== 10'h022) begin n_fail++; $display("FAIL hold_%0d got v=%b op=%h want v=1 op=022", i, out_valid_o, out_op_o); end
            cyc();
        end
        out_ready_i = 1'b1;
        #1;
        cyc();
        out_ready_i = 1'b0;
        alloc(10'h024, 1'b1, 32'd1, 1'b1, 32'd2);
        n_checks++; if (out_op_o !== 10'h023) begin n_fail++; $display("FAIL hold_next got %h want 023", out_op_o); end
        cyc();
        idle();
        n_checks++; if (out_op_o !== 10'h023) begin n_fail++; $display("FAIL age_not_index got %h want 023", out_op_o); end
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL age_count got %0d want 3", count_o); end
        cdb_valid_i = 2'b01; cdb_tag_i = {6'd0, 6'd12}; cdb_data_i = {32'h0, 32'h12};
        #1;
        cyc();
        idle();
        n_checks++; if (out_op_o !== 10'h021 || out_opr1_o !== 32'h12) begin n_fail++; $display("FAIL age_wake_oldest got op=%h opr1=%h want op=021 opr1=12", out_op_o, out_opr1_o); end
        out_ready_i = 1'b1;
        #1;
        cyc();
        n_checks++; if (out_valid_o !== 1'b1 || out_op_o !== 10'h023) begin n_fail++; $display("FAIL age_issue2 got v=%b op=%h want v=1 op=023", out_valid_o, out_op_o); end
        cyc();
        n_checks++; if (out_valid_o !== 1'b1 || out_op_o !== 10'h024) begin n_fail++; $display("FAIL age_issue3 got v=%b op=%h want v=1 op=024", out_valid_o, out_op_o); end
        cyc();
        n_checks++; if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin n_fail++; $display("FAIL age_drain got v=%b cnt=%0d want v=0 cnt=0", out_valid_o, count_o); end
    endtask

    task automatic test_flush(input logic use_reset);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alloc(10'h041 + 10'(i), 1'b1, 32'd1, 1'b1, 32'd2);
            cyc();
        end
        alloc(10'h044, 1'b1, 32'd1, 1'b1, 32'd2);
        if (use_reset) reset = 1'b1; else kill_i = 1'b1;
        #1;
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL flush%0d_pre_count got %0d want 3", use_reset, count_o); end
        if (!use_reset) begin
            n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL kill_cycle_valid got %b want 0", out_valid_o); end
        end
        cyc();
        reset = 1'b0;
        idle();
        out_ready_i = 1'b1;
        #1;
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL flush%0d_count got %0d want 0", use_reset, count_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush%0d_valid got %b want 0", use_reset, out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush%0d_in_ready got %b want 1", use_reset, in_ready_o); end
        cyc();
        n_checks++; if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin n_fail++; $display("FAIL flush%0d_after got v=%b cnt=%0d want v=0 cnt=0", use_reset, out_valid_o, count_o); end
    endtask

    initial begin
        in_op_i = '0; in_dest_i = '0; in_v1_i = 1'b0; in_v2_i = 1'b0;
        in_opr1_i = '0; in_opr2_i = '0; in_imm_i = '0;
        cdb_tag_i = '0; cdb_data_i = '0;
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_bypass();
        test_hold_age();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
